skinny_tweakey_schedule: RTL and testbench

Iterative tweakey schedule for the SKINNY-128 round-based core. It registers TK1 and TK2 (and TK3 when configured) on a load handshake and emits one 64-bit round tweakey per round to the downstream round function. Between rounds it advances each tweakey word through `TweakPerm`, then through the per-word LFSRs. It is the sequential wrapper that feeds and consumes `TweakPerm` every round.

---
 rtl/skinny_pkg.sv | 58 +++++
 rtl/TweakPerm.sv | 23 ++
 rtl/skinny_tweakey_schedule.sv | 155 +++++++++++++++
 tb/tb_skinny_tweakey_schedule.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/skinny_pkg.sv
// ---------------------------------------------------------------------------
// skinny_pkg
// Shared definitions for the SKINNY-128 tweakey schedule:
//   W             - cell width in bits (only 8 is supported)
//   SKINNY_R_TK2  - round count for SKINNY-128-256 (TK1 + TK2)
//   SKINNY_R_TK3  - round count for SKINNY-128-384 (TK1 + TK2 + TK3)
//   state_e       - schedule FSM states
//   TWEAK_PT      - tweakey cell permutation (new cell i <- old cell PT[i])
//   lfsr_tk2/3    - per-byte LFSR steps applied to rows 0-1 after permuting
// ---------------------------------------------------------------------------
package skinny_pkg;

  localparam int unsigned W            = 8;
  localparam int unsigned SKINNY_R_TK2 = 48;
  localparam int unsigned SKINNY_R_TK3 = 56;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Cell c of the permuted word is taken from cell TWEAK_PT[c] of the input.
  localparam logic [3:0] TWEAK_PT [16] = '{
    4'd9, 4'd15, 4'd8, 4'd13, 4'd10, 4'd14, 4'd12, 4'd11,
    4'd0, 4'd1,  4'd2, 4'd3,  4'd4,  4'd5,  4'd6,  4'd7
  };

  // TK2 byte LFSR: (x7..x0) -> (x6..x0, x7^x5)
  function automatic logic [7:0] lfsr_tk2(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5]};
  endfunction

  // TK3 byte LFSR: (x7..x0) -> (x0^x6, x7..x1)
  function automatic logic [7:0] lfsr_tk3(input logic [7:0] x);
    return {x[0] ^ x[6], x[7:1]};
  endfunction

  // Apply the TK2 LFSR to every byte of the upper (rows 0-1) half.
  function automatic logic [63:0] lfsr_tk2_half(input logic [63:0] h);
    logic [63:0] r;
    r = 64'd0;
    for (int b = 0; b < 8; b++) begin
      r[8*b +: 8] = lfsr_tk2(h[8*b +: 8]);
    end
    return r;
  endfunction

  // Apply the TK3 LFSR to every byte of the upper (rows 0-1) half.
  function automatic logic [63:0] lfsr_tk3_half(input logic [63:0] h);
    logic [63:0] r;
    r = 64'd0;
    for (int b = 0; b < 8; b++) begin
      r[8*b +: 8] = lfsr_tk3(h[8*b +: 8]);
    end
    return r;
  endfunction

endpackage

// File: rtl/TweakPerm.sv
// ---------------------------------------------------------------------------
// TweakPerm
// Pure combinational SKINNY tweakey cell permutation.
// Cell c occupies byte 15-c, i.e. cell 0 is the most significant byte.
// Ports:
//   tk_i  in  16*W : tweakey word before permutation
//   tk_o  out 16*W : permuted tweakey word
// ---------------------------------------------------------------------------
module TweakPerm #(
  parameter int unsigned W = 8
) (
  input  logic [16*W-1:0] tk_i,
  output logic [16*W-1:0] tk_o
);

  import skinny_pkg::*;

  for (genvar c = 0; c < 16; c++) begin : g_cell
    // Output cell c sits at byte 15-c; source cell TWEAK_PT[c] likewise.
    assign tk_o[(15-c)*W +: W] = tk_i[(15-int'(TWEAK_PT[c]))*W +: W];
  end

endmodule

// File: rtl/skinny_tweakey_schedule.sv
// ---------------------------------------------------------------------------
// skinny_tweakey_schedule
// Iterative SKINNY-128 tweakey schedule. Captures TK1/TK2 (and TK3 when the
// SKINNY_TK3_EN macro is defined) on a load handshake, then presents one
// 64-bit round tweakey per round. After each consumed round every word is
// permuted by TweakPerm and the upper half of TK2/TK3 is stepped by its LFSR.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  load handshake (ready only while idle)
//   tk1_in, tk2_in       tweakey words, byte b at [8b+7:8b], cell c = byte 15-c
//   tk3_in               third tweakey word (SKINNY_TK3_EN only)
//   rtk / rtk_valid      round tweakey (XOR of upper halves) and its valid
//   rtk_ready            downstream consumes rtk this cycle
//   round_idx            round number of the key on rtk
//   done                 one-cycle pulse after the last round is consumed
// Build option: SKINNY_TK3_EN adds TK3 and raises the default R to 56.
// ---------------------------------------------------------------------------
module skinny_tweakey_schedule #(
  parameter int unsigned W = skinny_pkg::W,
`ifdef SKINNY_TK3_EN
  parameter int unsigned R = skinny_pkg::SKINNY_R_TK3
`else
  parameter int unsigned R = skinny_pkg::SKINNY_R_TK2
`endif
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] tk1_in,
  input  logic [127:0] tk2_in,
`ifdef SKINNY_TK3_EN
  input  logic [127:0] tk3_in,
`endif
  output logic [63:0]  rtk,
  output logic         rtk_valid,
  input  logic         rtk_ready,
  output logic [5:0]   round_idx,
  output logic         done
);

  import skinny_pkg::*;

  localparam logic [5:0] LAST_ROUND = 6'(R - 1);

  state_e       state_q, state_d;
  logic [127:0] tk1_q, tk1_d, tk1_perm_s;
  logic [127:0] tk2_q, tk2_d, tk2_perm_s;
  logic [5:0]   round_q, round_d;
  logic         done_q, done_d;
`ifdef SKINNY_TK3_EN
  logic [127:0] tk3_q, tk3_d, tk3_perm_s;
`endif

  TweakPerm #(.W(W)) u_perm_tk1 (.tk_i(tk1_q), .tk_o(tk1_perm_s));
  TweakPerm #(.W(W)) u_perm_tk2 (.tk_i(tk2_q), .tk_o(tk2_perm_s));
`ifdef SKINNY_TK3_EN
  TweakPerm #(.W(W)) u_perm_tk3 (.tk_i(tk3_q), .tk_o(tk3_perm_s));
`endif

  // Next-state logic: load, advance one round per consume, clear on finish.
  always_comb begin
    state_d = state_q;
    tk1_d   = tk1_q;
    tk2_d   = tk2_q;
`ifdef SKINNY_TK3_EN
    tk3_d   = tk3_q;
`endif
    round_d = round_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          tk1_d   = tk1_in;
          tk2_d   = tk2_in;
`ifdef SKINNY_TK3_EN
          tk3_d   = tk3_in;
`endif
          round_d = 6'd0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (rtk_ready) begin
          if (round_q == LAST_ROUND) begin
            // Final key consumed: wipe key material so rtk reads 0 in IDLE.
            tk1_d   = 128'd0;
            tk2_d   = 128'd0;
`ifdef SKINNY_TK3_EN
            tk3_d   = 128'd0;
`endif
            round_d = 6'd0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            // LFSRs only touch rows 0-1 (upper half) of the permuted word.
            tk1_d   = tk1_perm_s;
            tk2_d   = {lfsr_tk2_half(tk2_perm_s[127:64]), tk2_perm_s[63:0]};
`ifdef SKINNY_TK3_EN
            tk3_d   = {lfsr_tk3_half(tk3_perm_s[127:64]), tk3_perm_s[63:0]};
`endif
            round_d = round_q + 6'd1;
          end
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
        tk1_d   = 128'd0;
        tk2_d   = 128'd0;
`ifdef SKINNY_TK3_EN
        tk3_d   = 128'd0;
`endif
        round_d = 6'd0;
      end
    endcase
  end

  // State and key registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tk1_q   <= 128'd0;
      tk2_q   <= 128'd0;
`ifdef SKINNY_TK3_EN
      tk3_q   <= 128'd0;
`endif
      round_q <= 6'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tk1_q   <= tk1_d;
      tk2_q   <= tk2_d;
`ifdef SKINNY_TK3_EN
      tk3_q   <= tk3_d;
`endif
      round_q <= round_d;
      done_q  <= done_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign rtk_valid = (state_q == RUN);
  assign round_idx = round_q;
  assign done      = done_q;
`ifdef SKINNY_TK3_EN
  assign rtk = tk1_q[127:64] ^ tk2_q[127:64] ^ tk3_q[127:64];
`else
  assign rtk = tk1_q[127:64] ^ tk2_q[127:64];
`endif

endmodule

// File: tb/tb_skinny_tweakey_schedule.sv
// ---------------------------------------------------------------------------
// tb_skinny_tweakey_schedule
// Scoreboard bench: each load pushes the full list of expected round keys,
// computed from a cell-array model of the SKINNY tweakey schedule; a monitor
// pops and compares on every consume and checks stall stability and done.
// ---------------------------------------------------------------------------
module tb_skinny_tweakey_schedule;

`ifdef SKINNY_TK3_EN
  localparam int R = 56;
`else
  localparam int R = 48;
`endif

  typedef struct {
    logic [63:0] rtk;
    logic [5:0]  idx;
    bit          last;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] tk1_in;
  logic [127:0] tk2_in;
`ifdef SKINNY_TK3_EN
  logic [127:0] tk3_in;
`endif
  logic [63:0]  rtk;
  logic         rtk_valid;
  logic         rtk_ready;
  logic [5:0]   round_idx;
  logic         done;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  bit   mon_en = 1'b0;
  int   rdy_mode = 1;   // 0: hold low, 1: always high, 2: random

  int   perm_tab [16] = '{9, 15, 8, 13, 10, 14, 12, 11, 0, 1, 2, 3, 4, 5, 6, 7};

  skinny_tweakey_schedule dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .tk1_in    (tk1_in),
    .tk2_in    (tk2_in),
`ifdef SKINNY_TK3_EN
    .tk3_in    (tk3_in),
`endif
    .rtk       (rtk),
    .rtk_valid (rtk_valid),
    .rtk_ready (rtk_ready),
    .round_idx (round_idx),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] step2(input logic [7:0] x);
    return ((x << 1) & 8'hFE) | (((x >> 7) ^ (x >> 5)) & 8'h01);
  endfunction

  function automatic logic [7:0] step3(input logic [7:0] x);
    return (x >> 1) | (((x ^ (x >> 6)) & 8'h01) << 7);
  endfunction

  // Model: keep each tweakey as 16 cells, cell c taken from byte 15-c.
  task automatic push_schedule(input logic [127:0] k1, input logic [127:0] k2,
                               input logic [127:0] k3);
    logic [7:0] c1 [16];
    logic [7:0] c2 [16];
    logic [7:0] c3 [16];
    logic [7:0] n1 [16];
    logic [7:0] n2 [16];
    logic [7:0] n3 [16];
    exp_t e;
    for (int c = 0; c < 16; c++) begin
      c1[c] = k1[8*(15-c) +: 8];
      c2[c] = k2[8*(15-c) +: 8];
      c3[c] = k3[8*(15-c) +: 8];
    end
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < 8; c++) e.rtk[8*(7-c) +: 8] = c1[c] ^ c2[c] ^ c3[c];
      e.idx  = 6'(r);
      e.last = (r == R - 1);
      sb_q.push_back(e);
      for (int i = 0; i < 16; i++) begin
        n1[i] = c1[perm_tab[i]];
        n2[i] = c2[perm_tab[i]];
        n3[i] = c3[perm_tab[i]];
      end
      for (int i = 0; i < 16; i++) begin
        c1[i] = n1[i];
        c2[i] = (i < 8) ? step2(n2[i]) : n2[i];
        c3[i] = (i < 8) ? step3(n3[i]) : n3[i];
      end
    end
  endtask

  task automatic drive_keys(input logic [127:0] k1, input logic [127:0] k2,
                            input logic [127:0] k3);
    tk1_in = k1;
    tk2_in = k2;
`ifdef SKINNY_TK3_EN
    tk3_in = k3;
`endif
    push_schedule(k1, k2, k3);
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic do_load(input logic [127:0] k1, input logic [127:0] k2,
                         input logic [127:0] k3);
    int n = 0;
    while (!in_ready && n < 500) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) chk("load_wait_timeout", 64'(in_ready), 64'd1);
`ifdef SKINNY_TK3_EN
    drive_keys(k1, k2, k3);
`else
    drive_keys(k1, k2, 128'd0);
`endif
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb_q.size() != 0 || !in_ready) && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    if (sb_q.size() != 0 || !in_ready) chk("idle_timeout", 64'(sb_q.size()), 64'd0);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // rtk_ready driver, kept clear of both the active edge and the sampling edge.
  initial begin
    rtk_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      case (rdy_mode)
        0:       rtk_ready = 1'b0;
        1:       rtk_ready = 1'b1;
        default: rtk_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: scoreboard compare on consume, stall stability, done timing.
  initial begin
    exp_t        e;
    logic [63:0] prev_rtk = 64'd0;
    logic [5:0]  prev_idx = 6'd0;
    bit          stall_prev = 1'b0;
    bit          exp_done = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (rst) begin
          stall_prev = 1'b0;
          exp_done   = 1'b0;
        end else begin
          chk("done", 64'(done), 64'(exp_done));
          exp_done = 1'b0;
          if (stall_prev) begin
            chk("stall_rtk", rtk, prev_rtk);
            chk("stall_idx", 64'(round_idx), 64'(prev_idx));
          end
          stall_prev = 1'b0;
          if (!rtk_valid) begin
            chk("idle_rtk", rtk, 64'd0);
          end else if (rtk_ready) begin
            if (sb_q.size() == 0) begin
              chk("unexpected_rtk", 64'(sb_q.size()), 64'd1);
            end else begin
              e = sb_q.pop_front();
              chk("rtk", rtk, e.rtk);
              chk("round_idx", 64'(round_idx), 64'(e.idx));
              exp_done = e.last;
            end
          end else begin
            stall_prev = 1'b1;
            prev_rtk   = rtk;
            prev_idx   = round_idx;
          end
        end
      end
    end
  end

  initial begin
    logic [127:0] a1, a2, a3;
    int n;
    rst = 1'b1; in_valid = 1'b0; tk1_in = 128'd0; tk2_in = 128'd0;
`ifdef SKINNY_TK3_EN
    tk3_in = 128'd0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_rtk_valid", 64'(rtk_valid), 64'd0);
    chk("rst_rtk", rtk, 64'd0);
    chk("rst_round_idx", 64'(round_idx), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    mon_en = 1'b1;

    // Directed: tk1 byte b = b, tk2 = 0.
    rdy_mode = 1;
    do_load(128'h0F0E0D0C0B0A09080706050403020100, 128'd0, 128'd0);
    chk("dir_round0", rtk, 64'h0F0E0D0C0B0A0908);
    @(posedge clk); #1;
    chk("dir_round1", rtk, 64'h0600070205010304);
    wait_idle();

    // Known-answer tweakeys with ready held high.
`ifdef SKINNY_TK3_EN
    do_load(128'hdf889548cfc7ea52d296339301797449, 128'hab588a34a47f1ab2dfe9c8293fbea9a5,
            128'hab1afac2611012cd8cef952618c3ebe8);
`else
    do_load(128'h009cec81605d4ac1d2ae9e3085d7a1f3, 128'h1ac123ebfc00fddcf01046ceeddfcab3,
            128'd0);
`endif
    wait_idle();

    // Random keys under a random ready pattern.
    rdy_mode = 2;
    for (int i = 0; i < 3; i++) begin
      do_load(rnd128(), rnd128(), rnd128());
      wait_idle();
    end

    // in_valid held high: second load must land exactly in the done cycle.
    rdy_mode = 1;
    a1 = rnd128(); a2 = rnd128(); a3 = rnd128();
`ifdef SKINNY_TK3_EN
    drive_keys(a1, a2, a3);
`else
    drive_keys(a1, a2, 128'd0);
`endif
    in_valid = 1'b1;
    @(posedge clk); #1;
    a1 = rnd128(); a2 = rnd128(); a3 = rnd128();
`ifdef SKINNY_TK3_EN
    drive_keys(a1, a2, a3);
`else
    drive_keys(a1, a2, 128'd0);
`endif
    n = 0;
    while (!done && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("b2b_done_seen", 64'(done), 64'd1);
    chk("b2b_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b_valid", 64'(rtk_valid), 64'd1);
    chk("b2b_round0", 64'(round_idx), 64'd0);
    wait_idle();

    // Reset in the middle of a schedule, then a fresh load.
    do_load(rnd128(), rnd128(), rnd128());
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    rdy_mode = 0;
    sb_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_valid", 64'(rtk_valid), 64'd0);
    chk("mid_rst_rtk", rtk, 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_idx", 64'(round_idx), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    rdy_mode = 1;
    do_load(rnd128(), rnd128(), rnd128());
    wait_idle();

    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
